// File: rtl/mc_exec_ctrl.sv
// Multi-cycle control FSM for the RV32I core: fetch handshake, decode, operand select,
// data memory sequencing, write-back and PC update, one instruction at a time.
module mc_exec_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] instr_in,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        br_taken,
    output logic [6:0]  op,
    output logic [2:0]  f3,
    output logic [6:0]  f7,
    output logic [31:0] ir_q,
    output logic [1:0]  alu_src_a,
    output logic        alu_src_b,
    output logic [1:0]  pc_src,
    output logic        pc_we,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [31:0] pc_rst_val,
    output logic        illegal,
    output logic        bus_err,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        st_fetch  = 3'd0,
        st_decode = 3'd1,
        st_exec   = 3'd2,
        st_mem    = 3'd3,
        st_wb     = 3'd4,
        st_trap   = 3'd5
    } state_t;

    localparam logic [6:0] opc_rtype  = 7'b0110011;
    localparam logic [6:0] opc_iimm   = 7'b0010011;
    localparam logic [6:0] opc_load   = 7'b0000011;
    localparam logic [6:0] opc_store  = 7'b0100011;
    localparam logic [6:0] opc_branch = 7'b1100011;
    localparam logic [6:0] opc_jal    = 7'b1101111;
    localparam logic [6:0] opc_jalr   = 7'b1100111;
    localparam logic [6:0] opc_lui    = 7'b0110111;
    localparam logic [6:0] opc_auipc  = 7'b0010111;

    localparam logic [7:0] tmo_last = 8'(MEM_TIMEOUT - 1);

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic        is_load_s;
    logic        is_store_s;
    logic        is_branch_s;

    function automatic logic opc_legal(input logic [6:0] opc);
        logic ok;
        case (opc)
            opc_rtype, opc_iimm, opc_load, opc_store, opc_branch,
            opc_jal, opc_jalr, opc_lui, opc_auipc: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign op         = ir_q[6:0];
    assign f3         = ir_q[14:12];
    assign f7         = ir_q[31:25];
    assign pc_rst_val = RESET_PC;

    assign is_load_s   = (ir_q[6:0] == opc_load);
    assign is_store_s  = (ir_q[6:0] == opc_store);
    assign is_branch_s = (ir_q[6:0] == opc_branch);

    // State sequencing, instruction latch, handshake timeout and sticky trap flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= st_fetch;
            cnt_r   <= 8'd0;
            ir_q    <= 32'd0;
            retired <= 32'd0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            case (state_r)
                st_fetch: begin
                    if (imem_ack) begin
                        ir_q    <= instr_in;
                        cnt_r   <= 8'd0;
                        state_r <= st_decode;
                    end else if (cnt_r == tmo_last) begin
                        bus_err <= 1'b1;
                        cnt_r   <= 8'd0;
                        state_r <= st_trap;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                st_decode: begin
                    cnt_r <= 8'd0;
                    if (opc_legal(ir_q[6:0])) begin
                        state_r <= st_exec;
                    end else begin
                        illegal <= 1'b1;
                        state_r <= st_trap;
                    end
                end
                st_exec: begin
                    cnt_r <= 8'd0;
                    if (is_load_s || is_store_s) begin
                        state_r <= st_mem;
                    end else if (is_branch_s) begin
                        retired <= retired + 32'd1;
                        state_r <= st_fetch;
                    end else begin
                        state_r <= st_wb;
                    end
                end
                st_mem: begin
                    if (dmem_ack) begin
                        cnt_r <= 8'd0;
                        if (is_store_s) begin
                            retired <= retired + 32'd1;
                            state_r <= st_fetch;
                        end else begin
                            state_r <= st_wb;
                        end
                    end else if (cnt_r == tmo_last) begin
                        bus_err <= 1'b1;
                        cnt_r   <= 8'd0;
                        state_r <= st_trap;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                st_wb: begin
                    cnt_r   <= 8'd0;
                    retired <= retired + 32'd1;
                    state_r <= st_fetch;
                end
                st_trap: begin
                    cnt_r   <= 8'd0;
                    state_r <= st_trap;
                end
                default: begin
                    cnt_r   <= 8'd0;
                    state_r <= st_fetch;
                end
            endcase
        end
    end

    // Datapath strobes and selects decoded from the state register and ir_q.
    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        alu_src_a = 2'd0;
        alu_src_b = 1'b0;
        pc_src    = 2'd0;
        pc_we     = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = 2'd0;
        case (state_r)
            st_fetch: begin
                // FETCH is also the reset state; hold the request low until rst drops.
                imem_req = ~rst;
            end
            st_exec: begin
                case (ir_q[6:0])
                    opc_auipc, opc_jal: alu_src_a = 2'd1;
                    opc_lui:            alu_src_a = 2'd2;
                    default:            alu_src_a = 2'd0;
                endcase
                case (ir_q[6:0])
                    opc_rtype, opc_branch: alu_src_b = 1'b0;
                    default:               alu_src_b = 1'b1;
                endcase
                if (is_branch_s) begin
                    pc_we  = 1'b1;
                    pc_src = br_taken ? 2'd1 : 2'd0;
                end else begin
                    pc_we  = 1'b0;
                    pc_src = 2'd0;
                end
            end
            st_mem: begin
                dmem_req = 1'b1;
                dmem_we  = is_store_s;
                if (is_store_s && dmem_ack) begin
                    pc_we = 1'b1;
                end else begin
                    pc_we = 1'b0;
                end
            end
            st_wb: begin
                rf_we = 1'b1;
                pc_we = 1'b1;
                case (ir_q[6:0])
                    opc_load:          wb_sel = 2'd1;
                    opc_jal, opc_jalr: wb_sel = 2'd2;
                    default:           wb_sel = 2'd0;
                endcase
                case (ir_q[6:0])
                    opc_jal:  pc_src = 2'd1;
                    opc_jalr: pc_src = 2'd2;
                    default:  pc_src = 2'd0;
                endcase
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_exec_ctrl.sv
// Directed bench for mc_exec_ctrl: each task drives one scenario and checks
// hand-computed strobe, select and counter values.
module tb_mc_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [31:0] instr_in = 32'd0;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack = 1'b0;
    logic        br_taken = 1'b0;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] ir_q;
    logic [1:0]  alu_src_a;
    logic        alu_src_b;
    logic [1:0]  pc_src;
    logic        pc_we;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic [31:0] pc_rst_val;
    logic        illegal;
    logic        bus_err;
    logic [31:0] retired;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int pcwe_cnt = 0;

    mc_exec_ctrl #(.MEM_TIMEOUT(16), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_ack(imem_ack), .instr_in(instr_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .br_taken(br_taken),
        .op(op), .f3(f3), .f7(f7), .ir_q(ir_q),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .pc_we(pc_we), .rf_we(rf_we), .wb_sel(wb_sel),
        .pc_rst_val(pc_rst_val), .illegal(illegal), .bus_err(bus_err),
        .retired(retired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Independent tally of PC load strobes, compared against retired.
    always @(negedge clk) begin
        if (rst) pcwe_cnt <= 0;
        else if (pc_we) pcwe_cnt <= pcwe_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word with an immediate ack; returns one cycle later in DECODE.
    task automatic fetch(input logic [31:0] w);
        instr_in = w;
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        vec_cnt++; if (imem_req !== 1'b0) begin err_cnt++; $display("FAIL rst_imem_req: got %b want 0", imem_req); end
        vec_cnt++; if ({dmem_req, pc_we, rf_we} !== 3'b000) begin err_cnt++; $display("FAIL rst_strobes: got %b want 000", {dmem_req, pc_we, rf_we}); end
        vec_cnt++; if (retired !== 32'd0) begin err_cnt++; $display("FAIL rst_retired: got %h want 0", retired); end
        vec_cnt++; if ({illegal, bus_err} !== 2'b00) begin err_cnt++; $display("FAIL rst_flags: got %b want 00", {illegal, bus_err}); end
        vec_cnt++; if (ir_q !== 32'd0) begin err_cnt++; $display("FAIL rst_ir: got %h want 0", ir_q); end
        vec_cnt++; if (pc_rst_val !== 32'h0000_0000) begin err_cnt++; $display("FAIL rst_pcval: got %h want 00000000", pc_rst_val); end
        rst = 1'b0;
        #1;
        vec_cnt++; if (imem_req !== 1'b1) begin err_cnt++; $display("FAIL rst_release_req: got %b want 1", imem_req); end
    endtask

    task automatic test_alu_imm();
        int c0;
        c0 = cyc;
        fetch(32'h00500093);
        vec_cnt++; if (op !== 7'h13 || f3 !== 3'd0 || ir_q !== 32'h00500093) begin err_cnt++; $display("FAIL addi_decode: got op=%h f3=%h ir=%h want 13 0 00500093", op, f3, ir_q); end
        vec_cnt++; if (imem_req !== 1'b0) begin err_cnt++; $display("FAIL addi_req_drop: got %b want 0", imem_req); end
        tick();
        vec_cnt++; if ({alu_src_a, alu_src_b, rf_we, pc_we} !== 5'b00100) begin err_cnt++; $display("FAIL addi_exec: got %b want 00100", {alu_src_a, alu_src_b, rf_we, pc_we}); end
        tick();
        vec_cnt++; if ({rf_we, pc_we, wb_sel, pc_src} !== 6'b110000) begin err_cnt++; $display("FAIL addi_wb: got %b want 110000", {rf_we, pc_we, wb_sel, pc_src}); end
        tick();
        vec_cnt++; if (retired !== 32'd1 || imem_req !== 1'b1) begin err_cnt++; $display("FAIL addi_retire: got ret=%0d req=%b want 1 1", retired, imem_req); end
        vec_cnt++; if (cyc - c0 !== 4) begin err_cnt++; $display("FAIL addi_latency: got %0d want 4", cyc - c0); end
    endtask

    task automatic test_jump_lui();
        fetch(32'h0000006F);
        tick();
        vec_cnt++; if ({alu_src_a, alu_src_b} !== 3'b011) begin err_cnt++; $display("FAIL jal_exec: got %b want 011", {alu_src_a, alu_src_b}); end
        tick();
        vec_cnt++; if ({wb_sel, pc_src, rf_we, pc_we} !== 6'b100111) begin err_cnt++; $display("FAIL jal_wb: got %b want 100111", {wb_sel, pc_src, rf_we, pc_we}); end
        tick();
        fetch(32'h00008067);
        tick();
        vec_cnt++; if ({alu_src_a, alu_src_b} !== 3'b001) begin err_cnt++; $display("FAIL jalr_exec: got %b want 001", {alu_src_a, alu_src_b}); end
        tick();
        vec_cnt++; if ({wb_sel, pc_src} !== 4'b1010) begin err_cnt++; $display("FAIL jalr_wb: got %b want 1010", {wb_sel, pc_src}); end
        tick();
        fetch(32'h000000B7);
        tick();
        vec_cnt++; if ({alu_src_a, alu_src_b} !== 3'b101) begin err_cnt++; $display("FAIL lui_exec: got %b want 101", {alu_src_a, alu_src_b}); end
        tick();
        vec_cnt++; if ({wb_sel, pc_src, rf_we} !== 5'b00001) begin err_cnt++; $display("FAIL lui_wb: got %b want 00001", {wb_sel, pc_src, rf_we}); end
        tick();
        vec_cnt++; if (retired !== 32'd4) begin err_cnt++; $display("FAIL jump_retired: got %0d want 4", retired); end
    endtask

    task automatic test_load_store();
        int c0;
        int held;
        c0 = cyc;
        held = 0;
        fetch(32'h0000A103);
        tick();
        vec_cnt++; if ({alu_src_a, alu_src_b} !== 3'b001) begin err_cnt++; $display("FAIL lw_exec: got %b want 001", {alu_src_a, alu_src_b}); end
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_ack = 1'b1;
            #1;
            if (dmem_req === 1'b1 && dmem_we === 1'b0 && pc_we === 1'b0) held++;
            tick();
        end
        dmem_ack = 1'b0;
        vec_cnt++; if (held !== 4) begin err_cnt++; $display("FAIL lw_dmem_hold: got %0d cycles want 4", held); end
        vec_cnt++; if ({rf_we, pc_we, wb_sel, dmem_req} !== 5'b11010) begin err_cnt++; $display("FAIL lw_wb: got %b want 11010", {rf_we, pc_we, wb_sel, dmem_req}); end
        tick();
        vec_cnt++; if (retired !== 32'd5 || cyc - c0 !== 8) begin err_cnt++; $display("FAIL lw_retire: got ret=%0d lat=%0d want 5 8", retired, cyc - c0); end
        c0 = cyc;
        fetch(32'h0020A023);
        tick();
        tick();
        vec_cnt++; if ({dmem_req, dmem_we, pc_we} !== 3'b110) begin err_cnt++; $display("FAIL sw_mem: got %b want 110", {dmem_req, dmem_we, pc_we}); end
        dmem_ack = 1'b1;
        #1;
        vec_cnt++; if ({pc_we, pc_src, rf_we} !== 4'b1000) begin err_cnt++; $display("FAIL sw_ack: got %b want 1000", {pc_we, pc_src, rf_we}); end
        tick();
        dmem_ack = 1'b0;
        vec_cnt++; if (retired !== 32'd6 || imem_req !== 1'b1 || cyc - c0 !== 4) begin err_cnt++; $display("FAIL sw_retire: got ret=%0d req=%b lat=%0d want 6 1 4", retired, imem_req, cyc - c0); end
    endtask

    task automatic test_branch();
        int c0;
        c0 = cyc;
        fetch(32'h00208463);
        tick();
        br_taken = 1'b1;
        #1;
        vec_cnt++; if ({pc_we, pc_src, rf_we, alu_src_b} !== 5'b10100) begin err_cnt++; $display("FAIL beq_taken: got %b want 10100", {pc_we, pc_src, rf_we, alu_src_b}); end
        tick();
        br_taken = 1'b0;
        vec_cnt++; if (retired !== 32'd7 || imem_req !== 1'b1 || cyc - c0 !== 3) begin err_cnt++; $display("FAIL beq_retire: got ret=%0d req=%b lat=%0d want 7 1 3", retired, imem_req, cyc - c0); end
        fetch(32'h00208463);
        tick();
        vec_cnt++; if ({pc_we, pc_src, rf_we} !== 4'b1000) begin err_cnt++; $display("FAIL beq_not_taken: got %b want 1000", {pc_we, pc_src, rf_we}); end
        tick();
        vec_cnt++; if (retired !== 32'd8) begin err_cnt++; $display("FAIL beq2_retire: got %0d want 8", retired); end
        vec_cnt++; if (pcwe_cnt !== 8) begin err_cnt++; $display("FAIL pcwe_per_retire: got %0d pulses want 8", pcwe_cnt); end
    endtask

    task automatic test_reset_mid_mem();
        fetch(32'h0000A103);
        tick();
        tick();
        vec_cnt++; if (dmem_req !== 1'b1) begin err_cnt++; $display("FAIL mid_mem_req: got %b want 1", dmem_req); end
        #2 rst = 1'b1;
        #1;
        vec_cnt++; if ({imem_req, dmem_req, pc_we, rf_we} !== 4'b0000 || retired !== 32'd0) begin err_cnt++; $display("FAIL async_rst_drop: got %b ret=%0d want 0000 0", {imem_req, dmem_req, pc_we, rf_we}, retired); end
        tick();
        rst = 1'b0;
        #1;
        vec_cnt++; if (imem_req !== 1'b1 || retired !== 32'd0 || pcwe_cnt !== 0) begin err_cnt++; $display("FAIL rst_restart: got req=%b ret=%0d pcwe=%0d want 1 0 0", imem_req, retired, pcwe_cnt); end
    endtask

    task automatic test_timeout();
        int held;
        held = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (imem_req === 1'b1) held++;
        end
        vec_cnt++; if (held !== 15 || bus_err !== 1'b0) begin err_cnt++; $display("FAIL tmo_wait: got held=%0d err=%b want 15 0", held, bus_err); end
        tick();
        vec_cnt++; if (bus_err !== 1'b1 || imem_req !== 1'b0) begin err_cnt++; $display("FAIL tmo_trap: got err=%b req=%b want 1 0", bus_err, imem_req); end
        instr_in = 32'h00500093;
        imem_ack = 1'b1;
        repeat (3) tick();
        imem_ack = 1'b0;
        vec_cnt++; if (ir_q !== 32'd0 || imem_req !== 1'b0 || retired !== 32'd0) begin err_cnt++; $display("FAIL tmo_late_ack: got ir=%h req=%b ret=%0d want 0 0 0", ir_q, imem_req, retired); end
    endtask

    task automatic test_illegal();
        int active;
        active = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        vec_cnt++; if ({illegal, bus_err} !== 2'b00) begin err_cnt++; $display("FAIL ill_clear: got %b want 00", {illegal, bus_err}); end
        fetch(32'hFFFFFFFF);
        vec_cnt++; if (illegal !== 1'b0) begin err_cnt++; $display("FAIL ill_decode: got %b want 0", illegal); end
        tick();
        vec_cnt++; if (illegal !== 1'b1) begin err_cnt++; $display("FAIL ill_trap: got %b want 1", illegal); end
        for (int i = 0; i < 20; i++) begin
            if (imem_req || dmem_req || pc_we || rf_we) active++;
            tick();
        end
        vec_cnt++; if (active !== 0) begin err_cnt++; $display("FAIL ill_absorb: got %0d active cycles want 0", active); end
    endtask

    initial begin
        test_reset();
        test_alu_imm();
        test_jump_lui();
        test_load_store();
        test_branch();
        test_reset_mid_mem();
        test_timeout();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
